branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 171 +++++++++++++++++
 tb/tb_branch_predictor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped table of saturating direction counters,
// jump flags and branch targets, with a registered one-cycle lookup port and
// a single resolve/update port fed from the ID stage.
// Optional feature: define BP_TAG_EN to add per-entry tags so that a hit
// also requires the PC tag to match. When it is not defined, an entry hits
// whenever it is valid, so PCs that share an index alias onto one entry.
module branch_predictor #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              lkp_valid,
  input  logic [DATA_W-1:0] lkp_pc,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              inv_all,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter landmarks: saturated, weakly taken (allocation), weakly not-taken (reset).
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  // Per-entry state. Valid, counter and jump flag are reset; target and tag
  // are only meaningful once valid is set, so they stay unreset.
  logic              valid_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];
  logic              jmp_q   [ENTRIES];
  logic [DATA_W-1:0] tgt_q   [ENTRIES];

  logic              pred_valid_q;
  logic              pred_taken_q;
  logic [DATA_W-1:0] pred_target_q;

  logic [IDX_W-1:0]  lkp_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic              lkp_tag_ok;
  logic              upd_tag_ok;
  logic              lkp_hit;
  logic              lkp_taken;
  logic [DATA_W-1:0] lkp_target;

  logic              upd_hit;
  logic              upd_dir_taken;
  logic              upd_we;
  logic              upd_tgt_we;
  logic [CTR_W-1:0]  upd_ctr_d;
  logic              upd_jmp_d;

  // The two lowest PC bits never take part in index or tag; they are folded
  // here so that the rest of the PC bits are visibly consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lkp_pc, upd_pc};

  assign lkp_idx = lkp_pc[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];

`ifdef BP_TAG_EN
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] lkp_tag;
  logic [TAG_W-1:0] upd_tag;

  assign lkp_tag    = lkp_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag    = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lkp_tag_ok = (tag_q[lkp_idx] == lkp_tag);
  assign upd_tag_ok = (tag_q[upd_idx] == upd_tag);
`else
  assign lkp_tag_ok = 1'b1;
  assign upd_tag_ok = 1'b1;
`endif

  // Lookup: combinational read of the current (pre-update) entry.
  always_comb begin
    lkp_hit    = valid_q[lkp_idx] && lkp_tag_ok;
    lkp_taken  = lkp_hit && (jmp_q[lkp_idx] || ctr_q[lkp_idx][CTR_W-1]);
    lkp_target = lkp_taken ? tgt_q[lkp_idx] : lkp_pc + DATA_W'(4);
  end

  // Update: decide whether and how the indexed entry changes this cycle.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    upd_hit       = valid_q[upd_idx] && upd_tag_ok;
    upd_dir_taken = !upd_is_branch || upd_taken;
    upd_we        = 1'b0;
    upd_tgt_we    = 1'b0;
    upd_ctr_d     = ctr_q[upd_idx];
    upd_jmp_d     = jmp_q[upd_idx];
    if (en && upd_valid && !inv_all) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (upd_dir_taken) begin
          upd_tgt_we = 1'b1;
          upd_jmp_d  = !upd_is_branch;
          upd_ctr_d  = (ctr_q[upd_idx] == CTR_MAX) ? CTR_MAX : ctr_q[upd_idx] + CTR_W'(1);
        end else begin
          upd_ctr_d  = (ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (upd_dir_taken) begin
        upd_we     = 1'b1;
        upd_tgt_we = 1'b1;
        upd_jmp_d  = !upd_is_branch;
        upd_ctr_d  = upd_is_branch ? CTR_WT : CTR_MAX;
      end
    end
  end

  // Table control state: reset, bulk invalidate, or single-entry update.
  // NOTE: this array is reset on purpose (valid/counter/jump have defined reset
  // values); the wide target/tag arrays live in a separate unreset block.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
        jmp_q[i]   <= 1'b0;
      end
    end else if (en) begin
      if (inv_all) begin
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (upd_we) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= upd_ctr_d;
        jmp_q[upd_idx]   <= upd_jmp_d;
      end
    end
  end

  // Target (and tag) storage: written only when an entry is allocated or taken-updated.
  always_ff @(posedge clk) begin
    if (upd_tgt_we) begin
      tgt_q[upd_idx] <= upd_target;
`ifdef BP_TAG_EN
      tag_q[upd_idx] <= upd_tag;
`endif
    end
  end

  // Prediction register: one-cycle lookup result, dropped by reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else if (en) begin
      pred_valid_q <= lkp_valid;
      if (lkp_valid) begin
        pred_taken_q  <= lkp_taken;
        pred_target_q <= lkp_target;
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (DATA_W=64, ENTRIES=64, CTR_W=2,
// TAG_W=8). Directed steps followed by randomized traffic, all compared
// against a table model that applies the predictor rules with plain integers.
module tb_branch_predictor;

  localparam int DATA_W  = 64;
  localparam int ENTRIES = 64;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              en = 1'b1;
  logic              lkp_valid = 1'b0;
  logic [DATA_W-1:0] lkp_pc = '0;
  logic              upd_valid = 1'b0;
  logic [DATA_W-1:0] upd_pc = '0;
  logic              upd_is_branch = 1'b0;
  logic              upd_taken = 1'b0;
  logic [DATA_W-1:0] upd_target = '0;
  logic              inv_all = 1'b0;
  logic              pred_valid;
  logic              pred_taken;
  logic [DATA_W-1:0] pred_target;

  int checks = 0;
  int failures = 0;

  // Reference table
  bit          m_valid [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_jump  [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_tag   [ENTRIES];

  // Last expected prediction, used for hold checks.
  bit          e_taken;
  logic [63:0] e_target;

  branch_predictor dut (
    .clk           (clk),
    .arst          (arst),
    .en            (en),
    .lkp_valid     (lkp_valid),
    .lkp_pc        (lkp_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_is_branch (upd_is_branch),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .inv_all       (inv_all),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [63:0] pc);
    return int'((pc / (4 * ENTRIES)) % 256);
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    int i = idx_of(pc);
`ifdef BP_TAG_EN
    return m_valid[i] && (m_tag[i] == tag_of(pc));
`else
    return m_valid[i];
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
      m_jump[i]  = 0;
    end
  endtask

  task automatic m_lookup(input logic [63:0] pc, output bit tk, output logic [63:0] tgt);
    int i = idx_of(pc);
    tk  = m_hit(pc) && (m_jump[i] || m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 64'd4;
  endtask

  task automatic m_update(input logic [63:0] pc, input bit is_br, input bit tk, input logic [63:0] tgt);
    int  i = idx_of(pc);
    bit  t = !is_br || tk;
    if (m_hit(pc)) begin
      if (t) begin
        m_ctr[i]  = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i]  = tgt;
        m_jump[i] = !is_br;
      end else begin
        m_ctr[i]  = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (t) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tgt;
      m_jump[i]  = !is_br;
      m_ctr[i]   = is_br ? 2 : 3;
    end
  endtask

  // One clock of traffic: drive at negedge, predict from the pre-edge model,
  // apply the model change, then sample just after the rising edge.
  task automatic cycle(input bit lv, input logic [63:0] lpc,
                       input bit uv, input logic [63:0] upc, input bit ub,
                       input bit ut, input logic [63:0] utgt,
                       input bit inv, input string tag);
    @(negedge clk);
    lkp_valid = lv;  lkp_pc = lpc;
    upd_valid = uv;  upd_pc = upc; upd_is_branch = ub; upd_taken = ut; upd_target = utgt;
    inv_all = inv;
    if (lv) m_lookup(lpc, e_taken, e_target);
    if (inv) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (uv) begin
      m_update(upc, ub, ut, utgt);
    end
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 64'(pred_valid), 64'(lv));
    if (lv) begin
      check({tag, ".taken"}, 64'(pred_taken), 64'(e_taken));
      check({tag, ".target"}, pred_target, e_target);
    end
    lkp_valid = 0; upd_valid = 0; inv_all = 0;
  endtask

  task automatic lookup(input logic [63:0] pc, input string tag);
    cycle(1, pc, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic update(input logic [63:0] pc, input bit is_br, input bit tk,
                        input logic [63:0] tgt, input string tag);
    cycle(0, 0, 1, pc, is_br, tk, tgt, 0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1;
    #1;
    check("rst.valid", 64'(pred_valid), 64'd0);
    check("rst.taken", 64'(pred_taken), 64'd0);
    check("rst.target", pred_target, 64'd0);
    m_reset();
    @(negedge clk);
    arst = 0;
  endtask

  initial begin
    logic [63:0] rpc, upc2, rtgt;
    bit          lv, uv, ub, ut, inv;

    m_reset();
    #2;
    check("init.valid", 64'(pred_valid), 64'd0);
    check("init.target", pred_target, 64'd0);
    do_reset();

    // Cold lookup: weakly not-taken, fall-through target.
    lookup(64'h40, "cold");
    check("cold.taken_direct", 64'(pred_taken), 64'd0);
    check("cold.target_direct", pred_target, 64'h44);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Training and saturation on 0x40.
    update(64'h40, 1, 1, 64'h100, "train0");
    lookup(64'h40, "trained");
    check("trained.target_direct", pred_target, 64'h100);
    repeat (3) update(64'h40, 1, 1, 64'h100, "train_more");
    update(64'h40, 1, 0, 64'h0, "nt1");
    lookup(64'h40, "after_nt1");
    check("after_nt1.taken_direct", 64'(pred_taken), 64'd1);
    update(64'h40, 1, 0, 64'h0, "nt2");
    update(64'h40, 1, 0, 64'h0, "nt3");
    lookup(64'h40, "after_nt3");
    check("after_nt3.target_direct", pred_target, 64'h44);
    repeat (2) update(64'h40, 1, 0, 64'h0, "nt_floor");
    lookup(64'h40, "floor");

    // Jump allocation then one not-taken branch update.
    update(64'h80, 0, 0, 64'h200, "jump");
    update(64'h80, 1, 0, 64'h0, "jump_nt");
    lookup(64'h80, "jump_look");
    check("jump_look.target_direct", pred_target, 64'h200);

    // Aliasing on a shared index.
    update(64'h40, 1, 1, 64'h100, "alias_upd");
    update(64'h40, 1, 1, 64'h100, "alias_upd2");
    lookup(64'h140, "alias");
`ifdef BP_TAG_EN
    check("alias.target_direct", pred_target, 64'h144);
`else
    check("alias.target_direct", pred_target, 64'h100);
`endif

    // Fall-through wraps modulo 2^64.
    lookup(64'hFFFF_FFFF_FFFF_FFFC, "wrap");

    // Read-before-write on a fresh table, then invalidate.
    do_reset();
    cycle(1, 64'h40, 1, 64'h40, 1, 1, 64'h100, 0, "rbw");
    check("rbw.taken_direct", 64'(pred_taken), 64'd0);
    lookup(64'h40, "rbw_next");
    check("rbw_next.taken_direct", 64'(pred_taken), 64'd1);
    // Invalidate with a concurrent lookup (sees old) and update (dropped).
    cycle(1, 64'h40, 1, 64'h80, 0, 1, 64'h300, 1, "inv");
    lookup(64'h40, "post_inv");
    check("post_inv.taken_direct", 64'(pred_taken), 64'd0);
    lookup(64'h80, "post_inv_upd");

    // Global enable low: nothing moves.
    update(64'h40, 1, 1, 64'h500, "retrain");
    lookup(64'h40, "pre_hold");
    @(negedge clk);
    en = 0; lkp_valid = 1; lkp_pc = 64'h80;
    upd_valid = 1; upd_pc = 64'h40; upd_is_branch = 1; upd_taken = 0;
    inv_all = 1;
    @(posedge clk);
    #1;
    check("hold.valid", 64'(pred_valid), 64'd1);
    check("hold.taken", 64'(pred_taken), 64'(e_taken));
    check("hold.target", pred_target, e_target);
    @(negedge clk);
    en = 1; lkp_valid = 0; upd_valid = 0; inv_all = 0;
    lookup(64'h40, "after_hold");

    // Reset right after a lookup edge drops the pending result and the table.
    lookup(64'h40, "pre_arst");
    #2;
    arst = 1;
    #1;
    check("arst_mid.valid", 64'(pred_valid), 64'd0);
    check("arst_mid.taken", 64'(pred_taken), 64'd0);
    check("arst_mid.target", pred_target, 64'd0);
    m_reset();
    @(negedge clk);
    arst = 0;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "post_arst_idle");
    lookup(64'h40, "post_arst");
    check("post_arst.taken_direct", 64'(pred_taken), 64'd0);

    // Randomized traffic over a small PC pool to force hits, aliasing and saturation.
    for (int n = 0; n < 400; n++) begin
      rpc  = 64'(($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2));
      upc2 = 64'(($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2));
      if ($urandom_range(0, 3) == 0) upc2 = rpc;
      rtgt = {$urandom, $urandom};
      lv   = ($urandom_range(0, 3) != 0);
      uv   = ($urandom_range(0, 2) != 0);
      ub   = ($urandom_range(0, 4) != 0);
      ut   = $urandom_range(0, 1);
      inv  = ($urandom_range(0, 59) == 0);
      cycle(lv, rpc, uv, upc2, ub, ut, rtgt, inv, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
